// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// Results are computed at issue into pending registers and committed to
// HI/LO only after the configured number of busy cycles has elapsed.
module mul_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in1E,
  input  logic [31:0] in2E,
  input  logic [3:0]  mdCtrE,
  input  logic        startE,
  output logic        busyE,
  output logic [31:0] mdOutE
);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8
  } op_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state, state_nx;
  logic [31:0] hi, lo, ph, pl;
  logic        pwr;
  logic [31:0] cnt;

  logic        accept_arith, accept_mthi, accept_mtlo, commit;

  logic [63:0] prod_s, prod_u;
  logic        signed_div, neg_a, neg_b, div_zero;
  logic [31:0] mag_a, mag_b, dvs, uq, ur;
  logic [31:0] pend_hi, pend_lo, pend_cnt;
  logic        pend_wr;

  // Result of the op on the operand bus, ready to latch at acceptance.
  // One unsigned divider serves both div and divu: signed division works on
  // magnitudes and restores signs afterwards, which also yields the
  // 0x80000000 / -1 wraparound without a special case.
  always_comb begin
    prod_s     = {{32{in1E[31]}}, in1E} * {{32{in2E[31]}}, in2E};
    prod_u     = {32'd0, in1E} * {32'd0, in2E};
    signed_div = (mdCtrE == OP_DIV);
    neg_a      = signed_div && in1E[31];
    neg_b      = signed_div && in2E[31];
    div_zero   = (in2E == '0);
    mag_a      = neg_a ? -in1E : in1E;
    mag_b      = neg_b ? -in2E : in2E;
    dvs        = div_zero ? 32'd1 : mag_b;
    uq         = mag_a / dvs;
    ur         = mag_a % dvs;
    pend_hi    = '0;
    pend_lo    = '0;
    pend_wr    = 1'b0;
    pend_cnt   = '0;
    case (mdCtrE)
      OP_MULT: begin
        pend_hi  = prod_s[63:32];
        pend_lo  = prod_s[31:0];
        pend_wr  = 1'b1;
        pend_cnt = 32'(MULT_CYCLES);
      end
      OP_MULTU: begin
        pend_hi  = prod_u[63:32];
        pend_lo  = prod_u[31:0];
        pend_wr  = 1'b1;
        pend_cnt = 32'(MULT_CYCLES);
      end
      OP_DIV, OP_DIVU: begin
        pend_lo  = (neg_a ^ neg_b) ? -uq : uq;
        pend_hi  = neg_a ? -ur : ur;
        pend_wr  = !div_zero;
        pend_cnt = 32'(DIV_CYCLES);
      end
      default: ;
    endcase
  end

  // Next-state and acceptance decode; ops are only taken in IDLE.
  always_comb begin
    state_nx     = state;
    accept_arith = 1'b0;
    accept_mthi  = 1'b0;
    accept_mtlo  = 1'b0;
    commit       = 1'b0;
    unique case (state)
      IDLE: begin
        if (startE) begin
          case (mdCtrE)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              accept_arith = 1'b1;
              state_nx     = RUN;
            end
            OP_MTHI: accept_mthi = 1'b1;
            OP_MTLO: accept_mtlo = 1'b1;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt <= 32'd1) begin
          commit   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Pending result, busy counter and committed HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi  <= '0;
      lo  <= '0;
      ph  <= '0;
      pl  <= '0;
      pwr <= 1'b0;
      cnt <= '0;
    end else begin
      if (accept_arith) begin
        ph  <= pend_hi;
        pl  <= pend_lo;
        pwr <= pend_wr;
        cnt <= pend_cnt;
      end else if (state == RUN) begin
        cnt <= commit ? '0 : cnt - 32'd1;
      end
      if (accept_mthi) hi <= in1E;
      if (accept_mtlo) lo <= in1E;
      if (commit && pwr) begin
        hi <= ph;
        lo <= pl;
      end
    end
  end

  // Status and read port; reads see committed HI/LO only.
  always_comb begin
    busyE = (state == RUN);
    case (mdCtrE)
      OP_MFHI: mdOutE = hi;
      OP_MFLO: mdOutE = lo;
      default: mdOutE = '0;
    endcase
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit with an expected-value scoreboard.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] in1E = '0;
  logic [31:0] in2E = '0;
  logic [3:0]  mdCtrE = '0;
  logic        startE = 1'b0;
  logic        busyE;
  logic [31:0] mdOutE;

  mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .in1E   (in1E),
    .in2E   (in2E),
    .mdCtrE (mdCtrE),
    .startE (startE),
    .busyE  (busyE),
    .mdOutE (mdOutE)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3, DIVU = 4'd4;
  localparam logic [3:0] MTHI = 4'd5, MTLO = 4'd6, MFHI = 4'd7, MFLO = 4'd8;

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;

  exp_t        sb[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Record expected HI/LO contents for the next read-back.
  task automatic push_exp(input string tag, input logic [31:0] h, input logic [31:0] l);
    hi_m = h;
    lo_m = l;
    sb.push_back('{{tag, "_hi"}, h});
    sb.push_back('{{tag, "_lo"}, l});
  endtask

  // Independent reference for the arithmetic ops.
  task automatic model_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b);
    longint          ps;
    longint unsigned pu;
    int              q, r;
    logic [31:0]     h, l;
    h = hi_m;
    l = lo_m;
    case (op)
      MULT: begin
        ps = longint'(int'(a)) * longint'(int'(b));
        h = ps[63:32];
        l = ps[31:0];
      end
      MULTU: begin
        pu = {32'd0, a} * {32'd0, b};
        h = pu[63:32];
        l = pu[31:0];
      end
      DIV: if (b != 0) begin
        q = int'(a) / int'(b);
        r = int'(a) % int'(b);
        h = r;
        l = q;
      end
      DIVU: if (b != 0) begin
        h = a % b;
        l = a / b;
      end
      default: ;
    endcase
    push_exp(tag, h, l);
  endtask

  // Pop two scoreboard entries and compare them with mfhi/mflo.
  task automatic read_hilo();
    exp_t e;
    if (sb.size() < 2) begin
      chk("sb_underflow", 32'(sb.size()), 32'd2);
    end else begin
      e = sb.pop_front();
      mdCtrE = MFHI;
      #1 chk(e.tag, mdOutE, e.v);
      e = sb.pop_front();
      mdCtrE = MFLO;
      #1 chk(e.tag, mdOutE, e.v);
      mdCtrE = 4'd9;
      #1 chk("mdout_other", mdOutE, 32'd0);
      mdCtrE = '0;
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    mdCtrE = op;
    in1E   = a;
    in2E   = b;
    startE = 1'b1;
  endtask

  // Pass the accepting edge, scramble operands, stop at the next falling edge.
  task automatic launch();
    @(posedge clk);
    #1;
    startE = 1'b0;
    mdCtrE = '0;
    in1E   = $urandom;
    in2E   = $urandom;
    @(negedge clk);
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    drive(op, a, b);
    launch();
  endtask

  // Count busy cycles from the current falling edge, bounded.
  task automatic wait_busy(input string tag, input int exp_n);
    int n = 0;
    while (busyE === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk(tag, 32'(n), 32'(exp_n));
  endtask

  initial begin
    int n;

    // Reset held with a start request pending: nothing may be accepted.
    drive(MTHI, 32'hDEAD_BEEF, 32'h0);
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busyE}, 32'd0);
    startE = 1'b0;
    push_exp("rst", 32'h0, 32'h0);
    read_hilo();

    // mult -7 x 3 issued on the first edge after reset release.
    @(negedge clk);
    reset = 1'b1;
    drive(MULT, 32'hFFFF_FFF9, 32'd3);
    launch();
    push_exp("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    wait_busy("mult_busy", 5);
    read_hilo();

    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    push_exp("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);
    wait_busy("multu_busy", 5);
    read_hilo();

    // div -7 / 2; reads during busy must still show the old LO.
    issue(DIV, 32'hFFFF_FFF9, 32'd2);
    mdCtrE = MFLO;
    #1 chk("lo_stale", mdOutE, 32'h0000_0001);
    mdCtrE = '0;
    push_exp("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    wait_busy("div_busy", 10);
    read_hilo();

    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    push_exp("div_ovf", 32'h0, 32'h8000_0000);
    wait_busy("div_ovf_busy", 10);
    read_hilo();

    issue(DIV, 32'd7, 32'hFFFF_FFFE);
    model_op("div_negb", DIV, 32'd7, 32'hFFFF_FFFE);
    wait_busy("div_negb_busy", 10);
    read_hilo();

    issue(DIVU, 32'hFFFF_FFF0, 32'd3);
    model_op("divu", DIVU, 32'hFFFF_FFF0, 32'd3);
    wait_busy("divu_busy", 10);
    read_hilo();

    issue(MULT, 32'h1234_5678, 32'h9ABC_DEF0);
    model_op("mult_mix", MULT, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_busy("mult_mix_busy", 5);
    read_hilo();

    // mthi/mtlo take effect with no busy cycles; divide by zero keeps HI/LO.
    issue(MTHI, 32'h11, 32'h0);
    chk("mthi_nobusy", {31'd0, busyE}, 32'd0);
    issue(MTLO, 32'h22, 32'h0);
    chk("mtlo_nobusy", {31'd0, busyE}, 32'd0);
    issue(DIVU, 32'd7, 32'd0);
    push_exp("divu_zero", 32'h11, 32'h22);
    wait_busy("divu_zero_busy", 10);
    read_hilo();

    // mtlo held through every busy cycle, including the one where busy falls.
    issue(MULT, 32'h0001_0001, 32'h0000_0100);
    drive(MTLO, 32'h55, 32'h0);
    n = 0;
    while (busyE === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("mtlo_busy", 32'(n), 32'd5);
    // Start in the cycle after busy falls is taken.
    drive(MTHI, 32'hAA, 32'h0);
    launch();
    chk("accept_after", {31'd0, busyE}, 32'd0);
    push_exp("mtlo_ign", 32'hAA, 32'h0100_0100);
    read_hilo();

    // Reset during busy cycle 4 of div 100/7 aborts with no commit.
    issue(DIV, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", {31'd0, busyE}, 32'd1);
    reset = 1'b0;
    #1 chk("rst_abort_busy", {31'd0, busyE}, 32'd0);
    push_exp("rst_abort", 32'h0, 32'h0);
    read_hilo();
    @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    chk("no_commit_busy", {31'd0, busyE}, 32'd0);
    push_exp("no_commit", 32'h0, 32'h0);
    read_hilo();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
